// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 inverse cipher: one shared round datapath stepped by a state machine,
// round keys expanded once per block and consumed from rk[NR] down to rk[0].
package aes_dec_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xtime(x);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    x = gf_inv(b);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

endpackage

module aes_key_expansion
  import aes_dec_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic [127:0] key,
  output logic [127:0] rk [0:NR]
);

  localparam int unsigned WORDS = 4 * (NR + 1);
  localparam int unsigned FLAT  = 32 * WORDS;

  function automatic logic [FLAT-1:0] expand(input logic [127:0] k);
    logic [31:0]     w [0:WORDS-1];
    logic [31:0]     t;
    logic [7:0]      rcon;
    logic [FLAT-1:0] flat;
    rcon = 8'h01;
    flat = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (i < NK) begin
        w[i] = k[127-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % NK == 0) begin
          t    = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
          rcon = xtime(rcon);
        end
        w[i] = w[i-NK] ^ t;
      end
      flat[FLAT-1-32*i -: 32] = w[i];
    end
    return flat;
  endfunction

  logic [FLAT-1:0] rk_flat;

  assign rk_flat = expand(key);

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk[r] = rk_flat[FLAT-1-128*r -: 128];
  end

endmodule

module aes_decrypt_top
  import aes_dec_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [127:0] i_ciphertext,
  input  logic [127:0] i_key,
  output logic [127:0] o_plaintext,
  output logic         o_valid,
  output logic         o_busy
);

  typedef enum logic [3:0] {
    IDLE, LOAD, INIT, ISHIFT, ISUB, IADD, IMIX, FINAL, DONE
  } state_t;

  state_t       state;
  logic [3:0]   rnd;
  logic [127:0] ct_reg;
  logic [127:0] key_reg;
  logic [127:0] st;
  logic [127:0] rk_reg [0:NR];
  logic [127:0] rk_exp [0:NR];

  aes_key_expansion #(.NK(NK), .NR(NR)) u_key_exp (
    .key (key_reg),
    .rk  (rk_exp)
  );

  // Byte n of the block sits at [127-8n -: 8], n = row + 4*col
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rnd         <= '0;
      ct_reg      <= '0;
      key_reg     <= '0;
      st          <= '0;
      o_plaintext <= '0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      for (int unsigned r = 0; r <= NR; r++) rk_reg[r] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            ct_reg  <= i_ciphertext;
            key_reg <= i_key;
            o_busy  <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          for (int unsigned r = 0; r <= NR; r++) rk_reg[r] <= rk_exp[r];
          state <= INIT;
        end
        INIT: begin
          st    <= ct_reg ^ rk_reg[NR];
          rnd   <= 4'(NR - 1);
          state <= ISHIFT;
        end
        ISHIFT: begin
          st    <= inv_shift_rows(st);
          state <= ISUB;
        end
        ISUB: begin
          st    <= inv_sub_bytes(st);
          state <= IADD;
        end
        IADD: begin
          st    <= st ^ rk_reg[rnd];
          state <= (rnd == 4'd0) ? FINAL : IMIX;
        end
        IMIX: begin
          st    <= inv_mix_columns(st);
          rnd   <= rnd - 4'd1;
          state <= ISHIFT;
        end
        // Output staging cycle: st already holds the final AddRoundKey result
        FINAL: begin
          o_plaintext <= st;
          o_valid     <= 1'b1;
          o_busy      <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          o_valid <= 1'b0;
          if (i_start) begin
            ct_reg  <= i_ciphertext;
            key_reg <= i_key;
            o_busy  <= 1'b1;
            state   <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_top.sv
// Bench for aes_decrypt_top: FIPS-197 vectors, latency/busy timing, ignored starts, mid-op reset,
// and back-to-back random round trips using a table-driven AES encryptor model.
module tb_aes_decrypt_top;

  logic         clk;
  logic         rst_n;
  logic         i_start;
  logic [127:0] i_ciphertext;
  logic [127:0] i_key;
  logic [127:0] o_plaintext;
  logic         o_valid;
  logic         o_busy;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] sbox_t [0:255];

  aes_decrypt_top #(.NK(4), .NR(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_ciphertext (i_ciphertext),
    .i_key        (i_key),
    .o_plaintext  (o_plaintext),
    .o_valid      (o_valid),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [127:0] k, input logic [127:0] c);
    i_key        = k;
    i_ciphertext = c;
    i_start      = 1'b1;
    step();
    i_start      = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (o_valid !== 1'b1 && edges < 100) begin
      step();
      edges++;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Reference forward cipher on a 16-byte array, s[r + 4c]
  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [0:43];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [0:15];
    logic [7:0]   u [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 44; i++) begin
      if (i < 4) w[i] = key[127-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % 4 == 0) begin
          t  = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
          rc = xt(rc);
        end
        w[i] = w[i-4] ^ t;
      end
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int n = 0; n < 16; n++) u[n] = sbox_t[s[n]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r+4*c] = u[r+4*((c+r)%4)];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rd + n/4][31-8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  initial begin
    logic [7:0]   p, q, x;
    logic [127:0] k, pt, cur_pt;
    int           e;
    int           vcount;

    // S-box table from the generator-3 walk over GF(2^8)
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;

    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_ciphertext = '0;
    i_key        = '0;
    step();
    step();
    check("reset_pt", o_plaintext, '0);
    check("reset_valid", o_valid, 0);
    check("reset_busy", o_busy, 0);
    rst_n = 1'b1;
    step();

    // FIPS-197 C.1 with cycle-accurate busy/valid checks
    start_op(128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("c1_busy_e0", o_busy, 1);
    for (int kk = 1; kk <= 41; kk++) begin
      step();
      check("c1_busy_window", o_busy, 1);
      check("c1_valid_early", o_valid, 0);
    end
    step();
    check("c1_busy_done", o_busy, 0);
    check("c1_valid", o_valid, 1);
    check("c1_pt", o_plaintext, 128'h00112233445566778899aabbccddeeff);
    step();
    check("c1_valid_pulse", o_valid, 0);
    check("c1_pt_hold", o_plaintext, 128'h00112233445566778899aabbccddeeff);
    check("c1_idle_busy", o_busy, 0);

    // FIPS-197 Appendix B
    start_op(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32);
    wait_done(e);
    check("appb_latency", e, 42);
    check("appb_pt", o_plaintext, 128'h3243f6a8885a308d313198a2e0370734);
    step();

    // Start pulse while busy is ignored; late input changes have no effect
    k  = rand128();
    pt = rand128();
    start_op(k, aes_enc(k, pt));
    repeat (9) step();
    start_op(rand128(), rand128());
    i_key        = rand128();
    i_ciphertext = rand128();
    wait_done(e);
    check("busy_start_latency", e, 32);
    check("busy_start_pt", o_plaintext, pt);
    step();

    // Reset in the middle of an operation
    k  = rand128();
    pt = rand128();
    start_op(k, aes_enc(k, pt));
    repeat (19) step();
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_pt", o_plaintext, '0);
    check("midrst_valid", o_valid, 0);
    check("midrst_busy", o_busy, 0);
    step();
    step();
    rst_n  = 1'b1;
    vcount = 0;
    for (int kk = 0; kk < 50; kk++) begin
      step();
      if (o_valid === 1'b1) vcount++;
    end
    check("midrst_no_valid", vcount, 0);
    check("midrst_idle_busy", o_busy, 0);
    k  = rand128();
    pt = rand128();
    start_op(k, aes_enc(k, pt));
    wait_done(e);
    check("after_rst_latency", e, 42);
    check("after_rst_pt", o_plaintext, pt);
    step();

    // Back-to-back random round trips: next start issued in the DONE cycle
    k      = rand128();
    cur_pt = rand128();
    start_op(k, aes_enc(k, cur_pt));
    for (int i = 0; i < 100; i++) begin
      wait_done(e);
      check("rt_latency", e, 42);
      check("rt_pt", o_plaintext, cur_pt);
      if (i < 99) begin
        k      = rand128();
        cur_pt = rand128();
        start_op(k, aes_enc(k, cur_pt));
      end
    end
    step();
    check("rt_valid_end", o_valid, 0);
    check("rt_busy_end", o_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
